pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 113 +++++++++++
 tb/tb_pc_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter and fetch sequencer: one FETCH/ISSUE pair per retired instruction.
// Stops in HALTED on halt, or in TRAP (with sticky misalign) on an unaligned next PC.
module pc_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EQ,
  input  logic                  branch,
  input  logic [DATA_WIDTH-1:0] imm_op,
  input  logic                  stall,
  input  logic                  halt,
  output logic                  fetch_req,
  input  logic                  fetch_ack,
  input  logic [DATA_WIDTH-1:0] instr_in,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic                  instr_valid,
  output logic                  misalign,
  output logic [DATA_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    HALTED = 3'd3,
    TRAP   = 3'd4
  } state_e;

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] retired_q;
  logic                  misalign_q;
  logic                  fetch_req_q;
  logic                  instr_valid_q;
  logic [DATA_WIDTH-1:0] pc_d;
  logic                  pc_bad;

  // Branch target or fall-through; the adder wraps naturally at 2^DATA_WIDTH.
  always_comb begin
    pc_d   = pc_q + ((branch && EQ) ? imm_op : PC_STEP);
    pc_bad = (pc_d[1:0] != 2'b00);
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // branch of the case reads the pre-edge values of the other registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      retired_q     <= '0;
      misalign_q    <= 1'b0;
      fetch_req_q   <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q     <= FETCH;
          fetch_req_q <= 1'b1;
        end
        FETCH: begin
          if (fetch_ack) begin
            instr_q       <= instr_in;
            state_q       <= ISSUE;
            fetch_req_q   <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        ISSUE: begin
          // Stall wins over halt and branch: nothing moves while it is high.
          if (!stall) begin
            instr_valid_q <= 1'b0;
            if (pc_bad) begin
              misalign_q <= 1'b1;
              state_q    <= TRAP;
            end else begin
              pc_q      <= pc_d;
              retired_q <= retired_q + DATA_WIDTH'(1);
              if (halt) begin
                state_q <= HALTED;
              end else begin
                state_q     <= FETCH;
                fetch_req_q <= 1'b1;
              end
            end
          end
        end
        HALTED, TRAP: begin
          state_q <= state_q;
        end
        default: begin
          state_q       <= IDLE;
          fetch_req_q   <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_req   = fetch_req_q;
  assign instr_valid = instr_valid_q;
  assign pc_out      = pc_q;
  assign instr_out   = instr_q;
  assign misalign    = misalign_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequential fetch, branches, fetch wait, stall/halt,
// misaligned trap, PC wrap and asynchronous reset, against hand-computed values.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EQ;
  logic        branch;
  logic [31:0] imm_op;
  logic        stall;
  logic        halt;
  logic        fetch_req;
  logic        fetch_ack;
  logic [31:0] instr_in;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        misalign;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  pc_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .EQ         (EQ),
    .branch     (branch),
    .imm_op     (imm_op),
    .stall      (stall),
    .halt       (halt),
    .fetch_req  (fetch_req),
    .fetch_ack  (fetch_ack),
    .instr_in   (instr_in),
    .pc_out     (pc_out),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .misalign   (misalign),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    EQ = 1'b0; branch = 1'b0; imm_op = '0; stall = 1'b0; halt = 1'b0;
    fetch_ack = 1'b0; instr_in = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " pc"},      pc_out,      32'h0);
    check({tag, " instr"},   instr_out,   32'h0);
    check({tag, " retired"}, retired,     32'h0);
    check({tag, " misal"},   {31'b0, misalign},    32'h0);
    check({tag, " freq"},    {31'b0, fetch_req},   32'h0);
    check({tag, " valid"},   {31'b0, instr_valid}, 32'h0);
  endtask

  // Reset asserted mid-cycle (async), released on a falling edge; DUT is then in IDLE.
  task automatic do_reset(input string tag);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1 check_reset_values(tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a falling edge with DUT in FETCH; leaves DUT in ISSUE.
  task automatic fetch(input logic [31:0] word);
    fetch_ack = 1'b1; instr_in = word;
    @(negedge clk);
    fetch_ack = 1'b0; instr_in = '0;
  endtask

  // Called at a falling edge with DUT in ISSUE; applies one issue cycle.
  task automatic issue(input logic br, input logic eq, input logic [31:0] imm, input logic hlt);
    branch = br; EQ = eq; imm_op = imm; halt = hlt; stall = 1'b0;
    @(negedge clk);
    branch = 1'b0; EQ = 1'b0; imm_op = '0; halt = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1 check_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle->fetch freq", {31'b0, fetch_req}, 32'h1);
    check("fetch pc0", pc_out, 32'h0);

    // Three sequential instructions: ISSUE at 0x0, 0x4, 0x8.
    for (int i = 0; i < 3; i++) begin
      fetch(32'h100 + 32'(i));
      check($sformatf("seq%0d valid", i), {31'b0, instr_valid}, 32'h1);
      check($sformatf("seq%0d pc", i), pc_out, 32'(4 * i));
      check($sformatf("seq%0d retired", i), retired, 32'(i));
      check($sformatf("seq%0d instr", i), instr_out, 32'h100 + 32'(i));
      issue(1'b0, 1'b0, '0, 1'b0);
    end
    check("seq end pc", pc_out, 32'hC);
    check("seq end retired", retired, 32'd3);

    fetch(32'h0); issue(1'b0, 1'b0, '0, 1'b0);
    check("pre-br pc", pc_out, 32'h10);
    fetch(32'h0); issue(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    check("br taken pc", pc_out, 32'h08);
    check("br taken retired", retired, 32'd5);
    fetch(32'h0); issue(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    check("eq only pc", pc_out, 32'h0C);
    fetch(32'h0); issue(1'b0, 1'b0, '0, 1'b0);
    fetch(32'h0); issue(1'b1, 1'b0, 32'hFFFF_FFF8, 1'b0);
    check("br not taken pc", pc_out, 32'h14);
    check("br not taken retired", retired, 32'd8);

    // Fetch wait: ack low for five cycles.
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wait%0d freq", i), {31'b0, fetch_req}, 32'h1);
      check($sformatf("wait%0d pc", i), pc_out, 32'h14);
      check($sformatf("wait%0d valid", i), {31'b0, instr_valid}, 32'h0);
      @(negedge clk);
    end
    fetch(32'h0000_0013);
    check("ack instr", instr_out, 32'h13);
    check("ack valid", {31'b0, instr_valid}, 32'h1);
    check("ack freq", {31'b0, fetch_req}, 32'h0);

    // Wrap: jump to 0xFFFF_FFFC, then fall through to 0.
    issue(1'b1, 1'b1, 32'hFFFF_FFE8, 1'b0);
    check("to top pc", pc_out, 32'hFFFF_FFFC);
    fetch(32'h0); issue(1'b0, 1'b0, '0, 1'b0);
    check("wrap pc", pc_out, 32'h0);
    check("wrap misal", {31'b0, misalign}, 32'h0);
    check("wrap freq", {31'b0, fetch_req}, 32'h1);
    check("wrap retired", retired, 32'd10);

    // Stall with halt and a taken branch pending: nothing moves for three cycles.
    fetch(32'h0);
    stall = 1'b1; halt = 1'b1; branch = 1'b1; EQ = 1'b1; imm_op = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d pc", i), pc_out, 32'h0);
      check($sformatf("stall%0d retired", i), retired, 32'd10);
      check($sformatf("stall%0d valid", i), {31'b0, instr_valid}, 32'h1);
    end
    stall = 1'b0; branch = 1'b0; EQ = 1'b0; imm_op = '0;
    @(negedge clk);
    halt = 1'b0;
    check("halt pc", pc_out, 32'h4);
    check("halt retired", retired, 32'd11);
    check("halt valid", {31'b0, instr_valid}, 32'h0);
    fetch_ack = 1'b1; instr_in = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("halted%0d freq", i), {31'b0, fetch_req}, 32'h0);
      check($sformatf("halted%0d pc", i), pc_out, 32'h4);
    end
    check("halted instr", instr_out, 32'h0);

    // Misaligned branch target traps at pc 0x4.
    do_reset("rst1");
    fetch(32'h0); issue(1'b0, 1'b0, '0, 1'b0);
    check("pre-trap pc", pc_out, 32'h4);
    fetch(32'h0); issue(1'b1, 1'b1, 32'h2, 1'b0);
    fetch_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("trap%0d misal", i), {31'b0, misalign}, 32'h1);
      check($sformatf("trap%0d pc", i), pc_out, 32'h4);
      check($sformatf("trap%0d retired", i), retired, 32'd1);
      check($sformatf("trap%0d freq", i), {31'b0, fetch_req}, 32'h0);
      check($sformatf("trap%0d valid", i), {31'b0, instr_valid}, 32'h0);
      @(negedge clk);
    end
    do_reset("rst2");
    check("post-trap freq", {31'b0, fetch_req}, 32'h1);

    // Reset asserted mid-ISSUE abandons the instruction.
    fetch(32'h55);
    check("mid valid", {31'b0, instr_valid}, 32'h1);
    do_reset("rst3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
